// File: rtl/parking_alert_pkg.sv
`default_nettype none
// ============================================================================
// Module      : parking_alert_pkg
// Description : Shared types and helpers for the parking alert LED sequencer.
//               - alert_state_t : per-channel sequencer state
//               - MODE_BURST / MODE_CONT : values of the per-channel mode input
//               - cnt_width()   : width of the phase/blink counters
// Revision    : 1.0 - initial release
// ============================================================================
package parking_alert_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } alert_state_t;

  localparam logic MODE_BURST = 1'b0;
  localparam logic MODE_CONT  = 1'b1;

  // Counters must hold the largest terminal value among the blink count and
  // the two phase lengths; +1 so that e.g. a max of 4 still gets 3 bits.
  function automatic int cnt_width(input int blinks, input int on_ticks,
                                   input int off_ticks);
    int m;
    m = blinks;
    if (on_ticks > m)  m = on_ticks;
    if (off_ticks > m) m = off_ticks;
    return $clog2(m + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/parking_alert_blinker_channel.sv
`default_nettype none
// ============================================================================
// Module      : alert_channel
// Description : One alert channel: trigger edge detect, IDLE/ON/OFF blink
//               sequencer with burst or continuous mode, retrigger and clear.
// Ports       : clk_1Hz  in  tick clock (rising edge)
//               reset    in  synchronous, active-low
//               trigger  in  alert request (synchronous to clk_1Hz)
//               mode     in  0 = burst of BLINKS blinks, 1 = continuous
//               clear    in  synchronous abort, wins over a simultaneous rise
//               led      out registered LED drive, high exactly in ON
//               busy     out registered, high in ON and OFF
//               done     out one-cycle pulse on normal completion
// Revision    : 1.0 - initial release
// ============================================================================
module alert_channel
  import parking_alert_pkg::*;
#(
  parameter int BLINKS    = 3,
  parameter int ON_TICKS  = 1,
  parameter int OFF_TICKS = 1
) (
  input  logic clk_1Hz,
  input  logic reset,
  input  logic trigger,
  input  logic mode,
  input  logic clear,
  output logic led,
  output logic busy,
  output logic done
);

  localparam int CNT_W = cnt_width(BLINKS, ON_TICKS, OFF_TICKS);

  localparam logic [CNT_W-1:0] c_on_last    = CNT_W'(ON_TICKS - 1);
  localparam logic [CNT_W-1:0] c_off_last   = CNT_W'(OFF_TICKS - 1);
  localparam logic [CNT_W-1:0] c_blink_last = CNT_W'(BLINKS - 1);
  localparam logic [CNT_W-1:0] c_cnt_max    = '1;

  alert_state_t     state_q, state_d;
  logic [CNT_W-1:0] phase_cnt_q, phase_cnt_d;
  logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             mode_q, mode_d;
  logic             trig_q, trig_d;
  logic             done_q, done_d;
  logic             led_q, led_d;
  logic             busy_q, busy_d;
  logic             w_rise;

  assign w_rise = trigger & ~trig_q;

  always_comb begin
    state_d     = state_q;
    phase_cnt_d = phase_cnt_q;
    blink_cnt_d = blink_cnt_q;
    mode_d      = mode_q;
    trig_d      = trigger;   // history follows the input even under clear
    done_d      = 1'b0;

    if (clear) begin
      state_d     = IDLE;
      phase_cnt_d = '0;
      blink_cnt_d = '0;
    end else if (w_rise) begin
      // Start or restart; an abandoned sequence never reports done.
      state_d     = ON;
      phase_cnt_d = '0;
      blink_cnt_d = '0;
      mode_d      = mode;
    end else begin
      case (state_q)
        ON: begin
          if (phase_cnt_q == c_on_last) begin
            state_d     = OFF;
            phase_cnt_d = '0;
          end else begin
            phase_cnt_d = phase_cnt_q + 1'b1;
          end
        end
        OFF: begin
          if (phase_cnt_q == c_off_last) begin
            phase_cnt_d = '0;
            // Saturating so a long continuous run cannot wrap the counter.
            if (blink_cnt_q != c_cnt_max) blink_cnt_d = blink_cnt_q + 1'b1;
            if (mode_q == MODE_BURST) begin
              if (blink_cnt_q == c_blink_last) begin
                state_d     = IDLE;
                blink_cnt_d = '0;
                done_d      = 1'b1;
              end else begin
                state_d = ON;
              end
            end else if (trigger) begin
              state_d = ON;
            end else begin
              state_d     = IDLE;
              blink_cnt_d = '0;
              done_d      = 1'b1;
            end
          end else begin
            phase_cnt_d = phase_cnt_q + 1'b1;
          end
        end
        IDLE:    ;
        default: state_d = IDLE;
      endcase
    end

    led_d  = (state_d == ON);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_1Hz) begin
    if (!reset) begin
      state_q     <= IDLE;
      phase_cnt_q <= '0;
      blink_cnt_q <= '0;
      mode_q      <= 1'b0;
      trig_q      <= 1'b0;
      done_q      <= 1'b0;
      led_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_cnt_q <= phase_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      mode_q      <= mode_d;
      trig_q      <= trig_d;
      done_q      <= done_d;
      led_q       <= led_d;
      busy_q      <= busy_d;
    end
  end

  assign led  = led_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
`default_nettype wire

// File: rtl/parking_alert_blinker.sv
`default_nettype none
// ============================================================================
// Module      : parking_alert_blinker
// Description : NUM_CH independent LED alert sequencers for the parking
//               controller front panel (lot full, gate fault, barrier open..).
// Ports       : clk_1Hz  in  1 Hz tick clock
//               reset    in  synchronous, active-low
//               trigger  in  [NUM_CH] per-channel alert request
//               mode     in  [NUM_CH] 0 = burst, 1 = continuous
//               clear    in  [NUM_CH] per-channel synchronous abort
//               led      out [NUM_CH] registered LED drive
//               busy     out [NUM_CH] channel not idle
//               done     out [NUM_CH] one-cycle completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
module parking_alert_blinker
  import parking_alert_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int BLINKS    = 3,
  parameter int ON_TICKS  = 1,
  parameter int OFF_TICKS = 1
) (
  input  logic              clk_1Hz,
  input  logic              reset,
  input  logic [NUM_CH-1:0] trigger,
  input  logic [NUM_CH-1:0] mode,
  input  logic [NUM_CH-1:0] clear,
  output logic [NUM_CH-1:0] led,
  output logic [NUM_CH-1:0] busy,
  output logic [NUM_CH-1:0] done
);

  // Channels share nothing but the clock and reset.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    alert_channel #(
      .BLINKS   (BLINKS),
      .ON_TICKS (ON_TICKS),
      .OFF_TICKS(OFF_TICKS)
    ) u_channel (
      .clk_1Hz(clk_1Hz),
      .reset  (reset),
      .trigger(trigger[i]),
      .mode   (mode[i]),
      .clear  (clear[i]),
      .led    (led[i]),
      .busy   (busy[i]),
      .done   (done[i])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_parking_alert_blinker.sv
`default_nettype none
// ============================================================================
// Module      : tb_parking_alert_blinker
// Description : Self-checking bench. Two DUTs share one stimulus stream:
//               dut_a (BLINKS=3, ON=1, OFF=1) and dut_b (BLINKS=2, ON=2,
//               OFF=3). Expected outputs come from a timeline model that
//               tracks elapsed cycles since sequence start per channel.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_parking_alert_blinker;

  logic       clk_1Hz = 1'b0;
  logic       reset   = 1'b0;
  logic [1:0] trigger = '0;
  logic [1:0] mode    = '0;
  logic [1:0] clear   = '0;
  logic [1:0] led_a, busy_a, done_a;
  logic [1:0] led_b, busy_b, done_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_1Hz = ~clk_1Hz;

  parking_alert_blinker #(.NUM_CH(2), .BLINKS(3), .ON_TICKS(1), .OFF_TICKS(1)) dut_a (
    .clk_1Hz(clk_1Hz), .reset(reset), .trigger(trigger), .mode(mode),
    .clear(clear), .led(led_a), .busy(busy_a), .done(done_a));

  parking_alert_blinker #(.NUM_CH(2), .BLINKS(2), .ON_TICKS(2), .OFF_TICKS(3)) dut_b (
    .clk_1Hz(clk_1Hz), .reset(reset), .trigger(trigger), .mode(mode),
    .clear(clear), .led(led_b), .busy(busy_b), .done(done_b));

  // ---------------- reference model: elapsed-time view of each channel ----
  int m_t    [2][2];   // cycles since the start edge (0 right after it)
  bit m_act  [2][2];
  bit m_mode [2][2];
  bit m_prev [2][2];
  bit m_done [2][2];

  function automatic int p_bl(int d);  return (d == 0) ? 3 : 2; endfunction
  function automatic int p_on(int d);  return (d == 0) ? 1 : 2; endfunction
  function automatic int p_off(int d); return (d == 0) ? 1 : 3; endfunction

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 2; c++) begin
        int per;
        bit rise;
        per = p_on(d) + p_off(d);
        m_done[d][c] = 1'b0;
        if (!reset) begin
          m_act[d][c] = 0; m_prev[d][c] = 0; m_t[d][c] = 0; m_mode[d][c] = 0;
        end else begin
          rise = trigger[c] && !m_prev[d][c];
          if (clear[c]) begin
            m_act[d][c] = 0;
          end else if (rise) begin
            m_act[d][c] = 1; m_t[d][c] = 0; m_mode[d][c] = mode[c];
          end else if (m_act[d][c]) begin
            m_t[d][c]++;
            if (m_t[d][c] % per == 0) begin
              if (!m_mode[d][c]) begin
                if (m_t[d][c] == p_bl(d) * per) begin
                  m_act[d][c] = 0; m_done[d][c] = 1;
                end
              end else if (!trigger[c]) begin
                m_act[d][c] = 0; m_done[d][c] = 1;
              end
            end
          end
          m_prev[d][c] = trigger[c];
        end
      end
    end
  endtask

  function automatic logic [11:0] exp_all();
    logic [1:0] l [2];
    logic [1:0] b [2];
    logic [1:0] n [2];
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 2; c++) begin
        l[d][c] = m_act[d][c] && ((m_t[d][c] % (p_on(d) + p_off(d))) < p_on(d));
        b[d][c] = m_act[d][c];
        n[d][c] = m_done[d][c];
      end
    end
    return {l[0], b[0], n[0], l[1], b[1], n[1]};
  endfunction

  function automatic logic [11:0] got();
    return {led_a, busy_a, done_a, led_b, busy_b, done_b};
  endfunction

  // Drive on the falling edge, let the model see the same rising edge,
  // then leave outputs settled 1 time unit after the edge for checking.
  task automatic step(input logic rst_n, input logic [1:0] trg,
                      input logic [1:0] md, input logic [1:0] clr);
    @(negedge clk_1Hz);
    reset = rst_n; trigger = trg; mode = md; clear = clr;
    @(posedge clk_1Hz);
    model_edge();
    #1;
  endtask

  // ---------------- scenarios ----------------------------------------------
  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      step((i >= 2), (i < 2) ? 2'b11 : 2'b00, 2'b00, 2'b00);
      n_vec++;
      if (got() !== 12'b0)
        begin n_err++; $display("FAIL reset[%0d]: got %b want %b", i, got(), 12'b0); end
      n_vec++;
      if (got() !== exp_all())
        begin n_err++; $display("FAIL reset_model[%0d]: got %b want %b", i, got(), exp_all()); end
    end
  endtask

  task automatic test_burst();
    for (int i = 0; i < 14; i++) begin
      step(1'b1, (i < 9) ? 2'b01 : 2'b00, 2'b00, 2'b00);
      n_vec++;
      if ({led_a[0], busy_a[0], done_a[0]} !== {(i < 6) && (i % 2 == 0), (i < 6), (i == 6)})
        begin n_err++; $display("FAIL burst_ch0[%0d]: got %b%b%b want %b%b%b", i,
          led_a[0], busy_a[0], done_a[0], (i < 6) && (i % 2 == 0), (i < 6), (i == 6)); end
      n_vec++;
      if (got() !== exp_all())
        begin n_err++; $display("FAIL burst_model[%0d]: got %b want %b", i, got(), exp_all()); end
    end
  endtask

  task automatic test_retrigger();
    for (int i = 0; i < 16; i++) begin
      logic el;
      el = (i <= 2) ? (i % 2 == 0) : ((i <= 8) && ((i - 3) % 2 == 0));
      step(1'b1, {1'b0, (i == 0) || (i >= 3 && i < 10)}, 2'b00, 2'b00);
      n_vec++;
      if ({led_a[0], done_a[0]} !== {el, (i == 9)})
        begin n_err++; $display("FAIL retrigger_ch0[%0d]: got %b%b want %b%b", i,
          led_a[0], done_a[0], el, (i == 9)); end
      n_vec++;
      if (got() !== exp_all())
        begin n_err++; $display("FAIL retrigger_model[%0d]: got %b want %b", i, got(), exp_all()); end
    end
  endtask

  task automatic test_clear();
    for (int i = 0; i < 14; i++) begin
      step(1'b1, {(i >= 4 && i < 8), (i < 6)}, 2'b00, {(i == 4), (i == 2)});
      n_vec++;
      if ({led_a, busy_a, done_a} !== {1'b0, (i == 0), 1'b0, (i < 2), 2'b00})
        begin n_err++; $display("FAIL clear[%0d]: got %b want %b", i,
          {led_a, busy_a, done_a}, {1'b0, (i == 0), 1'b0, (i < 2), 2'b00}); end
      n_vec++;
      if (got() !== exp_all())
        begin n_err++; $display("FAIL clear_model[%0d]: got %b want %b", i, got(), exp_all()); end
    end
  endtask

  task automatic test_continuous();
    for (int i = 0; i < 14; i++) begin
      step(1'b1, {(i <= 6), 1'b0}, 2'b10, 2'b00);
      n_vec++;
      if ({led_a[1], busy_a[1], done_a[1]} !== {(i <= 6) && (i % 2 == 0), (i <= 7), (i == 8)})
        begin n_err++; $display("FAIL continuous_ch1[%0d]: got %b%b%b want %b%b%b", i,
          led_a[1], busy_a[1], done_a[1], (i <= 6) && (i % 2 == 0), (i <= 7), (i == 8)); end
      n_vec++;
      if (got() !== exp_all())
        begin n_err++; $display("FAIL continuous_model[%0d]: got %b want %b", i, got(), exp_all()); end
    end
  endtask

  task automatic test_duty();
    for (int i = 0; i < 14; i++) begin
      logic el;
      el = (i == 0) || (i == 1) || (i == 5) || (i == 6);
      step(1'b1, {1'b0, (i == 0)}, 2'b00, 2'b00);
      n_vec++;
      if ({led_b[0], busy_b[0], done_b[0]} !== {el, (i < 10), (i == 10)})
        begin n_err++; $display("FAIL duty_b_ch0[%0d]: got %b%b%b want %b%b%b", i,
          led_b[0], busy_b[0], done_b[0], el, (i < 10), (i == 10)); end
      n_vec++;
      if (got() !== exp_all())
        begin n_err++; $display("FAIL duty_model[%0d]: got %b want %b", i, got(), exp_all()); end
    end
  endtask

  task automatic test_random();
    logic [1:0] trg, md, clr;
    logic       rst_n;
    trg = 2'b00;
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < 2; c++) begin
        if ($urandom_range(0, 5) == 0) trg[c] = ~trg[c];
        clr[c] = ($urandom_range(0, 15) == 0);
        md[c]  = $urandom_range(0, 1) != 0;
      end
      rst_n = ($urandom_range(0, 63) != 0);
      step(rst_n, trg, md, clr);
      n_vec++;
      if (got() !== exp_all())
        begin n_err++; $display("FAIL random[%0d]: got %b want %b", i, got(), exp_all()); end
    end
  endtask

  initial begin
    test_reset();
    test_burst();
    test_retrigger();
    test_clear();
    test_continuous();
    test_duty();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, got running want finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
